// File: rtl/lamp_pkg.sv
// Shared types and defaults for the lamp-control subsystem.
// The lamp timer's bench reuses the default debounce constants.
package lamp_pkg;

  localparam int unsigned N_SW          = 3;
  localparam int unsigned DB_CYCLES_DEF = 16;
  localparam int unsigned CNT_W_DEF     = 16;

  typedef enum logic [1:0] {
    STABLE_LOW,
    CHK_HIGH,
    STABLE_HIGH,
    CHK_LOW
  } db_state_t;

endpackage

// File: rtl/debounce_chan.sv
// One pushbutton channel: 2-flop synchronizer, debounce FSM, and a toggling level.
// The level flips and a one-cycle pulse fires only on an accepted press.
module debounce_chan
  import lamp_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic level_o,
  output logic pulse_o
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  logic [1:0]       sync_q;
  logic             sync;
  db_state_t        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             level_q;
  logic             pulse_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], btn_i};
    end
  end

  assign sync = sync_q[1];

  // The counter counts the samples already seen at the new level, so entering a
  // check state loads 1 and acceptance happens on the DB_CYCLES-th sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= STABLE_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      unique case (state_q)
        STABLE_LOW: begin
          if (sync) begin
            state_q <= CHK_HIGH;
            cnt_q   <= CntOne;
          end else begin
            cnt_q <= '0;
          end
        end
        CHK_HIGH: begin
          if (!sync) begin
            state_q <= STABLE_LOW;
            cnt_q   <= '0;
          end else if (cnt_q == CntLast) begin
            state_q <= STABLE_HIGH;
            cnt_q   <= '0;
            level_q <= ~level_q;
            pulse_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        STABLE_HIGH: begin
          if (!sync) begin
            state_q <= CHK_LOW;
            cnt_q   <= CntOne;
          end else begin
            cnt_q <= '0;
          end
        end
        CHK_LOW: begin
          if (sync) begin
            state_q <= STABLE_HIGH;
            cnt_q   <= '0;
          end else if (cnt_q == CntLast) begin
            // Releases are accepted silently: no toggle, no pulse.
            state_q <= STABLE_LOW;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        default: begin
          state_q <= STABLE_LOW;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign level_o = level_q;
  assign pulse_o = pulse_q;

endmodule

// File: rtl/switch_toggle_gen.sv
// Conditions three bouncy pushbuttons into toggling switch levels for the lamp timer.
// any_press lets the timer retrigger even when two levels flip in the same cycle.
module switch_toggle_gen
  import lamp_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_SW-1:0] btn_raw,
  output logic [N_SW-1:0] sw_level,
  output logic [N_SW-1:0] press_pulse,
  output logic            any_press
);

  for (genvar i = 0; i < N_SW; i++) begin : g_chan
    debounce_chan #(
      .DB_CYCLES(DB_CYCLES),
      .CNT_W    (CNT_W)
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn_i  (btn_raw[i]),
      .level_o(sw_level[i]),
      .pulse_o(press_pulse[i])
    );
  end

  assign any_press = |press_pulse;

endmodule

// File: tb/tb_switch_toggle_gen.sv
// Scoreboard bench for switch_toggle_gen: a run-length reference model predicts presses,
// a negedge monitor compares pulses, any_press and switch levels every cycle.
module tb_switch_toggle_gen;
  import lamp_pkg::*;

  localparam int unsigned DB = 4;
  localparam int unsigned CW = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] btn_raw = 3'b000;
  logic [2:0] sw_level;
  logic [2:0] press_pulse;
  logic       any_press;

  switch_toggle_gen #(
    .DB_CYCLES(DB),
    .CNT_W    (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .sw_level   (sw_level),
    .press_pulse(press_pulse),
    .any_press  (any_press)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic [2:0]  mask;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned cyc   = 0;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference model: a channel's accepted level flips once DB consecutive
  // synchronized samples disagree with it; a flip to high is a press.
  logic [2:0] m_s1, m_s2, m_acc, m_sw;
  int         m_run [3];

  always @(posedge clk or negedge rst_n) begin
    logic [2:0] mask;
    if (!rst_n) begin
      m_s1 = 3'b000; m_s2 = 3'b000; m_acc = 3'b000; m_sw = 3'b000;
      for (int i = 0; i < 3; i++) m_run[i] = 0;
      sb_q.delete();
    end else begin
      cyc++;
      mask = 3'b000;
      for (int i = 0; i < 3; i++) begin
        if (m_s2[i] != m_acc[i]) begin
          m_run[i]++;
          if (m_run[i] == int'(DB)) begin
            m_run[i] = 0;
            m_acc[i] = ~m_acc[i];
            if (m_acc[i]) begin
              mask[i] = 1'b1;
              m_sw[i] = ~m_sw[i];
            end
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = btn_raw;
      if (mask != 3'b000) sb_q.push_back('{cyc: cyc, mask: mask});
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [2:0] exp_mask;
    exp_t       e;
    if (!rst_n) begin
      chk("reset_outputs", 32'({sw_level, press_pulse, any_press}), 32'd0);
    end else begin
      exp_mask = 3'b000;
      if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
        e = sb_q.pop_front();
        exp_mask = e.mask;
      end
      chk("press_pulse", 32'(press_pulse), 32'(exp_mask));
      chk("any_press", 32'(any_press), 32'(exp_mask != 3'b000));
      chk("sw_level", 32'(sw_level), 32'(m_sw));
      chk("xor_level", 32'(^sw_level), 32'(^m_sw));
    end
  end

  task automatic hold(input logic [2:0] b, input int n);
    btn_raw = b;
    repeat (n) @(negedge clk);
  endtask

  // Asynchronous reset landing between clock edges; outputs must clear at once.
  task automatic async_reset(input logic [2:0] b_during);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_clear", 32'({sw_level, press_pulse, any_press}), 32'd0);
    btn_raw = b_during;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    hold(3'b000, 4);

    // Clean press then release on channel 0.
    hold(3'b001, 20);
    hold(3'b000, 10);
    // Reset in the middle of a check on channel 0.
    hold(3'b001, 3);
    async_reset(3'b000);
    hold(3'b000, 8);
    // Bounce on channel 1.
    hold(3'b010, 3);
    hold(3'b000, 1);
    hold(3'b010, 10);
    hold(3'b000, 10);
    // Press, release, press on channel 2.
    hold(3'b100, 10);
    hold(3'b000, 10);
    hold(3'b100, 10);
    hold(3'b000, 10);
    // Simultaneous presses on channels 0 and 1.
    hold(3'b011, 10);
    hold(3'b000, 10);
    // Channel 2 held through reset.
    async_reset(3'b100);
    hold(3'b100, 12);
    hold(3'b000, 10);

    for (int k = 0; k < 400; k++) begin
      if (k == 200) async_reset(3'($urandom));
      hold(3'($urandom), int'($urandom_range(1, 2 * DB + 2)));
    end

    hold(3'b000, 20);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
